// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_pkg
//  Description : Shared types and constants for the sprite fetch path:
//                fetch FSM state encoding, visible screen size and the
//                default transparent (key) colour of the pose ROMs.
//  Revision    : 1.0 - initial release
// ============================================================================
package sprite_pkg;

  // Fetch FSM states, explicitly encoded in two bits.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,  // after reset, nothing latched
    ARMED  = 2'd1,  // position latched, waiting for the first sprite row
    ACTIVE = 2'd2,  // scanning rows inside the sprite box
    DONE   = 2'd3   // past the last sprite row of this frame
  } state_t;

  // Visible screen area; anything beyond is blanking and never drawn.
  localparam int unsigned H_RES = 640;
  localparam int unsigned V_RES = 480;

  // Palette entry that marks a transparent sprite pixel.
  localparam logic [23:0] KEY_COLOR_DEF = 24'h800080;

endpackage : sprite_pkg
`default_nettype wire

// File: rtl/sprite_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_fetch_unit
//  Description : Read-side initiator for one external pose ROM. Generates the
//                ROM address from incremental row/column counters and turns
//                the returned colour into a registered, transparency-keyed
//                pixel stream. Sprite position and facing are latched once
//                per frame on frame_start.
//  Revision    : 1.0 - initial release
//
//  Ports
//    Clk           in   system clock
//    Reset         in   asynchronous, active-high reset
//    pix_en        in   pixel strobe; all state advances only on it
//    frame_start   in   one-strobe pulse at vertical sync
//    DrawX, DrawY  in   current scan pixel
//    sprite_x/_y   in   sprite top-left position (latched per frame)
//    flip          in   1 = mirror horizontally (latched per frame)
//    rom_color     in   combinational ROM data for read_address
//    read_address  out  registered ROM address
//    sprite_on     out  registered opaque-pixel flag
//    sprite_rgb    out  registered pixel colour (0 when sprite_on is low)
//
//  Latency: pixel sampled on strobe N -> read_address after N,
//           sprite_on / sprite_rgb after strobe N+1.
// ============================================================================
module sprite_fetch_unit
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_W     = 21,
  parameter int unsigned SPR_H     = 41,
  parameter int unsigned ADDR_W    = 10,
  parameter logic [23:0] KEY_COLOR = KEY_COLOR_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              pix_en,
  input  logic              frame_start,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        sprite_x,
  input  logic [9:0]        sprite_y,
  input  logic              flip,
  input  logic [23:0]       rom_color,
  output logic [ADDR_W-1:0] read_address,
  output logic              sprite_on,
  output logic [23:0]       sprite_rgb
);

  localparam int unsigned ROW_W = $clog2(SPR_H);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [9:0]          pos_x_q;
  logic [9:0]          pos_y_q;
  logic                flip_q;
  logic [ADDR_W-1:0]   row_base_q;     // row_idx_q * SPR_W, kept incrementally
  logic [ROW_W-1:0]    row_idx_q;
  logic [9:0]          prev_y_q;       // DrawY seen on the previous strobe
  logic                inbox_q;        // in-box flag of the pixel now being read
  logic [ADDR_W-1:0]   read_address_q;
  logic                sprite_on_q;
  logic [23:0]         sprite_rgb_q;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic                y_changed;
  logic                row_last;
  logic                x_in_range;
  logic                on_screen;
  logic [9:0]          col;
  logic [9:0]          col_sel;
  logic [ADDR_W-1:0]   row_base_eff;
  logic [ADDR_W-1:0]   addr_d;
  logic                sprite_on_d;

  // FSM output-process signals
  logic                scan_row;       // current strobe belongs to a sprite row
  logic                row_adv;        // advance row counters this strobe
  logic                inbox_d;

  assign y_changed = (DrawY != prev_y_q);
  assign row_last  = (row_idx_q == ROW_W'(SPR_H - 1));

  // 11-bit compare so pos_x + SPR_W past 1023 cannot wrap.
  assign x_in_range = ({1'b0, DrawX} >= {1'b0, pos_x_q}) &&
                      ({1'b0, DrawX} <  ({1'b0, pos_x_q} + 11'(SPR_W)));

  // Blanking coordinates must never draw, even if they fall in the box.
  assign on_screen  = ({22'd0, DrawX} < H_RES) && ({22'd0, DrawY} < V_RES);

  assign col     = DrawX - pos_x_q;
  assign col_sel = flip_q ? (10'(SPR_W - 1) - col) : col;

  // On the strobe that opens a new row the address must already use the
  // advanced base, not the one still in row_base_q.
  assign row_base_eff = row_adv ? (row_base_q + ADDR_W'(SPR_W)) : row_base_q;
  assign addr_d       = row_base_eff + ADDR_W'(col_sel);

  assign sprite_on_d  = inbox_q && (rom_color != KEY_COLOR);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
    end else if (pix_en) begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic (frame_start overrides everything)
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (frame_start) begin
      state_d = ARMED;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        ARMED:   if (DrawY == pos_y_q)         state_d = ACTIVE;
        ACTIVE:  if (y_changed && row_last)    state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM: output logic
  // The strobe on which ARMED sees the first sprite row already scans that
  // row, so the leftmost column is not lost when it coincides with entry.
  // --------------------------------------------------------------------------
  always_comb begin
    scan_row = 1'b0;
    row_adv  = 1'b0;
    if (!frame_start) begin
      case (state_q)
        ARMED: begin
          scan_row = (DrawY == pos_y_q);
        end
        ACTIVE: begin
          scan_row = !(y_changed && row_last);
          row_adv  = y_changed && !row_last;
        end
        default: begin
          scan_row = 1'b0;
          row_adv  = 1'b0;
        end
      endcase
    end
    inbox_d = scan_row && x_in_range && on_screen;
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pos_x_q        <= '0;
      pos_y_q        <= '0;
      flip_q         <= 1'b0;
      row_base_q     <= '0;
      row_idx_q      <= '0;
      prev_y_q       <= '0;
      inbox_q        <= 1'b0;
      read_address_q <= '0;
      sprite_on_q    <= 1'b0;
      sprite_rgb_q   <= '0;
    end else if (pix_en) begin
      prev_y_q     <= DrawY;
      inbox_q      <= inbox_d;
      sprite_on_q  <= sprite_on_d;
      sprite_rgb_q <= sprite_on_d ? rom_color : 24'd0;

      if (frame_start) begin
        pos_x_q    <= sprite_x;
        pos_y_q    <= sprite_y;
        flip_q     <= flip;
        row_base_q <= '0;
        row_idx_q  <= '0;
      end else if (row_adv) begin
        row_base_q <= row_base_q + ADDR_W'(SPR_W);
        row_idx_q  <= row_idx_q + ROW_W'(1);
      end

      // Outside the box the address simply holds.
      if (inbox_d) begin
        read_address_q <= addr_d;
      end
    end
  end

  assign read_address = read_address_q;
  assign sprite_on    = sprite_on_q;
  assign sprite_rgb   = sprite_rgb_q;

endmodule : sprite_fetch_unit
`default_nettype wire

// File: tb/tb_sprite_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_fetch_unit
//  Description : Directed, self-checking bench for sprite_fetch_unit with a
//                behavioural pose ROM and an output scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_fetch_unit;

  localparam logic [23:0] KEY = 24'h800080;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        pix_en;
  logic        frame_start;
  logic [9:0]  DrawX, DrawY;
  logic [9:0]  sprite_x, sprite_y;
  logic        flip;
  logic [23:0] rom_color;
  logic [9:0]  read_address;
  logic        sprite_on;
  logic [23:0] sprite_rgb;

  typedef struct packed {
    logic        on;
    logic [23:0] rgb;
  } exp_t;

  exp_t        sb[$];
  logic [9:0]  m_addr;
  int          n_total = 0;
  int          n_pass  = 0;

  always #5 Clk = ~Clk;

  sprite_fetch_unit dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .pix_en       (pix_en),
    .frame_start  (frame_start),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .sprite_x     (sprite_x),
    .sprite_y     (sprite_y),
    .flip         (flip),
    .rom_color    (rom_color),
    .read_address (read_address),
    .sprite_on    (sprite_on),
    .sprite_rgb   (sprite_rgb)
  );

  // Pose ROM model: address 5 is transparent, 6 is a fixed colour.
  function automatic logic [23:0] rom(input logic [9:0] a);
    if (a == 10'd5)      return KEY;
    else if (a == 10'd6) return 24'hF83800;
    else                 return {4'hA, a, a ^ 10'h155};
  endfunction

  always_comb rom_color = rom(read_address);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One pixel strobe, then an idle cycle (registers must hold), then checks.
  task automatic step(input int x, input int y, input bit fs,
                      input bit exp_in, input int exp_a);
    exp_t e;
    @(negedge Clk);
    DrawX       = 10'(x);
    DrawY       = 10'(y);
    frame_start = fs;
    pix_en      = 1'b1;
    @(negedge Clk);
    pix_en      = 1'b0;
    frame_start = 1'b0;
    @(negedge Clk);
    if (exp_in) m_addr = 10'(exp_a);
    chk("read_address", 32'(read_address), 32'(m_addr));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sprite_on",  32'(sprite_on),  32'(e.on));
      chk("sprite_rgb", 32'(sprite_rgb), 32'(e.rgb));
    end
    e.on  = exp_in && (rom(m_addr) != KEY);
    e.rgb = e.on ? rom(m_addr) : 24'd0;
    sb.push_back(e);
  endtask

  task automatic new_frame(input int px, input int py, input bit f);
    sprite_x = 10'(px);
    sprite_y = 10'(py);
    flip     = f;
    step(0, 0, 1'b1, 1'b0, 0);
  endtask

  initial begin
    Reset = 1'b1; pix_en = 1'b0; frame_start = 1'b0;
    DrawX = '0; DrawY = '0; sprite_x = '0; sprite_y = '0; flip = 1'b0;
    m_addr = '0;
    #12;
    chk("reset_addr", 32'(read_address), 32'd0);
    chk("reset_on",   32'(sprite_on),    32'd0);
    chk("reset_rgb",  32'(sprite_rgb),   32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    sb.push_back('0);

    // No output in IDLE even over the would-be box.
    step(100, 0, 1'b0, 1'b0, 0);

    // Frame 1: pos (100,200), no flip, full sprite then past its last row.
    new_frame(100, 200, 1'b0);
    sprite_x = 10'd300;  // mid-frame input changes have no effect
    step(0, 199, 1'b0, 1'b0, 0);
    for (int x = 99; x <= 122; x++)
      step(x, 200, 1'b0, (x >= 100 && x <= 120), x - 100);
    for (int y = 201; y <= 240; y++) begin
      step(100, y, 1'b0, 1'b1, (y - 200) * 21);
      step(120, y, 1'b0, 1'b1, (y - 200) * 21 + 20);
      step(121, y, 1'b0, 1'b0, 0);
    end
    step(100, 241, 1'b0, 1'b0, 0);
    step(110, 241, 1'b0, 1'b0, 0);
    step(100, 242, 1'b0, 1'b0, 0);

    // Frame 2: mirrored.
    new_frame(100, 200, 1'b1);
    flip = 1'b0;
    for (int y = 200; y <= 201; y++)
      for (int x = 99; x <= 121; x++)
        step(x, y, 1'b0, (x >= 100 && x <= 120), (y - 200) * 21 + 20 - (x - 100));

    // Frame 3: clipped at the bottom-right screen edge, then blanking.
    new_frame(630, 470, 1'b0);
    for (int y = 469; y <= 479; y++)
      for (int x = 628; x <= 639; x++)
        step(x, y, 1'b0, (y >= 470 && x >= 630), (y - 470) * 21 + (x - 630));
    for (int x = 630; x <= 633; x++)
      step(x, 480, 1'b0, 1'b0, 0);

    // Frame 4: re-latch from an unfinished frame.
    new_frame(10, 10, 1'b0);
    step(9, 10, 1'b0, 1'b0, 0);
    step(10, 10, 1'b0, 1'b1, 0);
    step(11, 10, 1'b0, 1'b1, 1);

    // Frame 5: reset in the middle of ACTIVE.
    new_frame(100, 200, 1'b0);
    for (int y = 200; y <= 210; y++)
      step(110, y, 1'b0, 1'b1, (y - 200) * 21 + 10);
    #2 Reset = 1'b1;
    #1;
    chk("midrst_addr", 32'(read_address), 32'd0);
    chk("midrst_on",   32'(sprite_on),    32'd0);
    chk("midrst_rgb",  32'(sprite_rgb),   32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    sb.delete();
    sb.push_back('0);
    m_addr = '0;
    step(110, 210, 1'b0, 1'b0, 0);
    step(111, 210, 1'b0, 1'b0, 0);
    step(110, 211, 1'b0, 1'b0, 0);
    new_frame(100, 200, 1'b0);
    step(100, 200, 1'b0, 1'b1, 0);
    step(105, 200, 1'b0, 1'b1, 5);
    step(106, 200, 1'b0, 1'b1, 6);
    step(107, 200, 1'b0, 1'b1, 7);
    step(0, 200, 1'b0, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_sprite_fetch_unit
`default_nettype wire
